// File: rtl/trap_ctrl_pkg.sv
// Shared ISA constants for the M-mode trap controller: cause codes, mtvec modes, FSM states.
// Pure declarations; no logic, no latency, no backpressure.
package trap_ctrl_pkg;

    localparam logic [4:0] EXC_INST_MISALIGNED = 5'd0;
    localparam logic [4:0] EXC_ILLEGAL_INST    = 5'd2;
    localparam logic [4:0] EXC_BREAKPOINT      = 5'd3;
    localparam logic [4:0] EXC_ECALL_M         = 5'd11;

    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_MEI = 5'd11;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } trap_state_t;

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Level synchroniser for one asynchronous interrupt request line.
// Latency: SYNC_STAGES cycles; no backpressure (free-running flop chain).
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_b,
    input  logic irq_i,
    output logic irq_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
        end
    end

    assign irq_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// M-mode trap controller: prioritises interrupts/exceptions/mret into a registered fetch redirect.
// Latency: one cycle from committed event to trap/CSR strobes; stall held until fetch asserts trap_ready.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              inst_valid,
    input  logic [XLEN-1:0]   pc,
    input  logic              inst_misaligned,
    input  logic              illegal_inst,
    input  logic              ebreak,
    input  logic              ecall,
    input  logic              mret,
    input  logic [XLEN-1:0]   bad_value,
    input  logic              irq_sw,
    input  logic              irq_timer,
    input  logic              irq_ext,
    input  logic              csr_rd_mstatus_mie,
    input  logic              csr_rd_mstatus_mpie,
    input  logic [2:0]        csr_rd_mie,
    input  logic [XLEN-3:0]   csr_rd_mtvec_base,
    input  logic [1:0]        csr_rd_mtvec_mode,
    input  logic [XLEN-1:0]   csr_rd_mepc_mepc,
    output logic              trap,
    input  logic              trap_ready,
    output logic [XLEN-1:0]   trap_pc,
    output logic              stall,
    output logic              ent_trap,
    output logic              ext_trap,
    output logic [XLEN-1:0]   csr_wr_mepc_mepc,
    output logic [XLEN-2:0]   csr_wr_mcause_exception_code,
    output logic              csr_wr_mcause_interrupt,
    output logic [XLEN-1:0]   csr_wr_mtval,
    output logic              csr_wr_mstatus_mie,
    output logic              csr_wr_mstatus_mpie,
    output logic [2:0]        mip
);

    trap_state_t     state_q;
    logic            trap_q, ent_q, ext_q, intr_q, mie_q, mpie_q;
    logic [XLEN-1:0] trap_pc_q, mepc_q, mtval_q;
    logic [4:0]      code_q;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sw  (.clk(clk), .rst_b(rst_b), .irq_i(irq_sw),    .irq_o(mip[0]));
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tmr (.clk(clk), .rst_b(rst_b), .irq_i(irq_timer), .irq_o(mip[1]));
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (.clk(clk), .rst_b(rst_b), .irq_i(irq_ext),   .irq_o(mip[2]));

    logic [2:0]      pend;
    logic            take_irq, take_entry, take_mret;
    logic [4:0]      code_d;
    logic [XLEN-1:0] mtval_d, base_addr, target_d;

    always_comb begin
        pend       = mip & csr_rd_mie;
        take_irq   = (|pend) && csr_rd_mstatus_mie;
        take_entry = 1'b1;
        take_mret  = 1'b0;
        code_d     = EXC_ECALL_M;
        mtval_d    = '0;
        // Interrupts outrank every exception flag and mret of the same instruction.
        if (take_irq) begin
            code_d = pend[2] ? IRQ_MEI : (pend[0] ? IRQ_MSI : IRQ_MTI);
        end else if (inst_misaligned) begin
            code_d  = EXC_INST_MISALIGNED;
            mtval_d = bad_value;
        end else if (illegal_inst) begin
            code_d  = EXC_ILLEGAL_INST;
            mtval_d = bad_value;
        end else if (ebreak) begin
            code_d  = EXC_BREAKPOINT;
            mtval_d = pc;
        end else if (ecall) begin
            code_d  = EXC_ECALL_M;
        end else begin
            take_entry = 1'b0;
            take_mret  = mret;
        end

        base_addr = {csr_rd_mtvec_base, 2'b00};
        target_d  = base_addr;
        if (VECTORED_EN && take_irq && (csr_rd_mtvec_mode == MTVEC_VECTORED)) begin
            target_d = base_addr + {{(XLEN-7){1'b0}}, code_d, 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_IDLE;
            trap_q    <= 1'b0;
            ent_q     <= 1'b0;
            ext_q     <= 1'b0;
            intr_q    <= 1'b0;
            mie_q     <= 1'b0;
            mpie_q    <= 1'b0;
            trap_pc_q <= '0;
            mepc_q    <= '0;
            mtval_q   <= '0;
            code_q    <= '0;
        end else begin
            ent_q <= 1'b0;
            ext_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (inst_valid && take_entry) begin
                        state_q   <= ST_REDIRECT;
                        trap_q    <= 1'b1;
                        ent_q     <= 1'b1;
                        trap_pc_q <= target_d;
                        mepc_q    <= pc;
                        code_q    <= code_d;
                        intr_q    <= take_irq;
                        mtval_q   <= mtval_d;
                        mpie_q    <= csr_rd_mstatus_mie;
                        mie_q     <= 1'b0;
                    end else if (inst_valid && take_mret) begin
                        state_q   <= ST_REDIRECT;
                        trap_q    <= 1'b1;
                        ext_q     <= 1'b1;
                        trap_pc_q <= csr_rd_mepc_mepc;
                        mie_q     <= csr_rd_mstatus_mpie;
                        mpie_q    <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    if (trap_ready) begin
                        state_q <= ST_IDLE;
                        trap_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    trap_q  <= 1'b0;
                end
            endcase
        end
    end

    assign trap                         = trap_q;
    assign trap_pc                      = trap_pc_q;
    assign stall                        = (state_q == ST_REDIRECT);
    assign ent_trap                     = ent_q;
    assign ext_trap                     = ext_q;
    assign csr_wr_mepc_mepc             = mepc_q;
    assign csr_wr_mcause_exception_code = {{(XLEN-6){1'b0}}, code_q};
    assign csr_wr_mcause_interrupt      = intr_q;
    assign csr_wr_mtval                 = mtval_q;
    assign csr_wr_mstatus_mie           = mie_q;
    assign csr_wr_mstatus_mpie          = mpie_q;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap controller for the single-cycle/short-pipeline core. Generational successor to the ecall/mret-only handler.
- Handles multiple synchronous exception causes and the three standard M-mode interrupts (software, timer, external), with prioritisation.
- Supports direct and vectored mtvec, save/restore of mstatus.MIE/MPIE, and mtval.
- Delivers a registered redirect to the fetch unit with a valid/ready handshake, and holds the core stalled until the redirect is accepted.

Parameters:
- XLEN, 32, datapath/CSR width.
- SYNC_STAGES, 2, flop stages on each asynchronous irq input (≥2).
- VECTORED_EN, 1, 1 = honour mtvec.mode==1; 0 = treat every mode as direct.

Ports:
- clk  in  1  core clock.
- rst_b  in  1  asynchronous active-low reset.
- inst_valid  in  1  instruction in the commit stage is valid this cycle.
- pc  in  XLEN  PC of the committing instruction.
- inst_misaligned / illegal_inst / ebreak / ecall / mret  in  1 each  exception/return flags of the committing instruction.
- bad_value  in  XLEN  faulting address or instruction bits, written to mtval.
- irq_sw / irq_timer / irq_ext  in  1 each  asynchronous interrupt requests.
- csr_rd_mstatus_mie / csr_rd_mstatus_mpie  in  1 each  current mstatus bits.
- csr_rd_mie  in  3  enables {meie, mtie, msie}.
- csr_rd_mtvec_base  in  XLEN-2  trap vector base.
- csr_rd_mtvec_mode  in  2  trap vector mode.
- csr_rd_mepc_mepc  in  XLEN  return address.
- trap  out  1  redirect valid to fetch.
- trap_ready  in  1  fetch has accepted the redirect.
- trap_pc  out  XLEN  redirect target.
- stall  out  1  hold commit/fetch while a redirect is outstanding.
- ent_trap  out  1  one-cycle CSR write strobe for trap entry.
- ext_trap  out  1  one-cycle CSR write strobe for mret.
- csr_wr_mepc_mepc  out  XLEN  mepc write data.
- csr_wr_mcause_exception_code  out  XLEN-1  mcause code.
- csr_wr_mcause_interrupt  out  1  mcause interrupt bit.
- csr_wr_mtval  out  XLEN  mtval write data.
- csr_wr_mstatus_mie / csr_wr_mstatus_mpie  out  1 each  mstatus write data.
- mip  out  3  synchronised pending bits {meip, mtip, msip}, for CSR read.

Behaviour:
- Reset: state IDLE. All outputs, including all registered CSR write data, are 0. Synchroniser flops are 0.
- Interrupt synchronisers:
  - Each irq passes through SYNC_STAGES flops.
  - mip equals the last stage.
  - Level sensitive; no latching. Clearing is the source's responsibility.
- Event evaluation occurs in IDLE only, on a cycle with inst_valid=1. The candidate is chosen in this priority order:
  1. Interrupt: take when (mip & csr_rd_mie) != 0 and csr_rd_mstatus_mie=1. Among interrupts, priority is MEI(11) > MSI(3) > MTI(7). mepc=pc (instruction not committed). mtval=0.
  2. inst_misaligned: code 0, mtval=bad_value.
  3. illegal_inst: code 2, mtval=bad_value.
  4. ebreak: code 3, mtval=pc.
  5. ecall: code 11, mtval=0.
  6. mret: return.
- Any taken interrupt suppresses every exception flag and mret of that instruction.
- Entry effects: MPIE<=MIE, MIE<=0.
- Entry target:
  - Base address is {base,2'b0}.
  - For interrupts only, when VECTORED_EN=1 and mode==1, target is base address + 4*code.
  - Otherwise target is the base address.
  - Mode 2/3 is treated as direct.
- mret effects: trap_pc=csr_rd_mepc_mepc, MIE<=MPIE, MPIE<=1, mcause unchanged.
- Latency: an event sampled at cycle N produces, at cycle N+1, trap=1, registered trap_pc, and registered CSR write data. ent_trap (or ext_trap) is 1 for exactly cycle N+1.
- FSM states: IDLE and REDIRECT.
  - IDLE -> REDIRECT when an event is taken.
  - REDIRECT -> IDLE when trap && trap_ready.
  - If trap_ready=1 already in cycle N+1, the FSM returns to IDLE at N+2.
  - trap and trap_pc stay stable until accepted.
- stall=1 whenever state is REDIRECT.
- Events presented during REDIRECT are ignored; the core must not commit during REDIRECT.
- Flags with inst_valid=0 are ignored.
- Asynchronous reset mid-REDIRECT returns the FSM to IDLE and drops trap immediately.

Decomposition:
- Shared package riscv_isa.svh:
  - exception codes: INST_MISALIGNED=0, ILLEGAL_INST=2, BREAKPOINT=3, ECALL_M=11.
  - interrupt codes: MSI=3, MTI=7, MEI=11.
  - mtvec mode encodings: DIRECT=0, VECTORED=1.
  - FSM state enum.
- One sub-module: irq_sync, a parametrised SYNC_STAGES flop chain instantiated 3 times.

Test Plan:
- ecall at pc=0x8000_0010, mtvec=0x8000_0100 direct, MIE=1 → next cycle:
  - trap=1, trap_pc=0x8000_0100.
  - mepc=0x8000_0010, code=11, interrupt=0, mtval=0.
  - MPIE=1, MIE=0, ent_trap single pulse.
- illegal_inst with bad_value=0xDEAD_BEEF plus ecall in the same cycle → code=2, mtval=0xDEAD_BEEF (illegal wins).
- irq_timer and irq_ext raised, mie=3'b111, MIE=1, vectored mtvec base 0x8000_0000:
  - Taken SYNC_STAGES+1 cycles after the raise (next valid inst).
  - code=11, interrupt=1, trap_pc=0x8000_002C.
  - The ecall flag on that instruction is suppressed.
- Same interrupt with MIE=0 → no trap. mip=3'b110 is still visible.
- mret with mepc=0x8000_0044, MPIE=1 → trap_pc=0x8000_0044, MIE=1, MPIE=1, ext_trap pulse.
- Handshake: trap_ready held 0 for 3 cycles:
  - trap, trap_pc and stall are held.
  - A second ecall in the hold window is ignored.
  - Setting trap_ready=1 returns the FSM to IDLE the next cycle.
  - Asserting rst_b=0 during the hold clears trap asynchronously.
